sync_timing_recovery: RTL and testbench
=======================================

Name: sync_timing_recovery

Overview:
- Receiving end of the VGA sync interface. Takes active-high hsync/vsync as produced by the crt_controller sync generator and recovers beam position (hpos/vpos) and display_on.
- Measures line and frame periods and reports lock.
- Sits after the generator, or on an external sync input in the same clock domain. Used for loopback checking and for overlay logic that must track an incoming raster.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_BOTTOM, 10, vertical front porch
- V_SYNC, 2, vsync lines
- V_TOP, 33, vertical back porch
- LOCK_COUNT, 4, consecutive matching periods required for lock (1..15)
- Derived (localparam):
  - H_TOTAL=800, H_MAX=H_TOTAL-1, H_SYNC_START=H_DISPLAY+H_FRONT=656
  - V_TOTAL=525, V_MAX=V_TOTAL-1, V_SYNC_START=V_DISPLAY+V_BOTTOM=490
  - H_TIMEOUT=2*H_TOTAL, V_TIMEOUT=2*V_TOTAL

Ports:
- clk  input  1  pixel clock
- reset  input  1  asynchronous, active-low reset
- hsync  input  1  horizontal sync, active high, synchronous to clk
- vsync  input  1  vertical sync, active high, synchronous to clk
- hpos  output  10  recovered horizontal position
- vpos  output  10  recovered vertical position
- display_on  output  1  locked && hpos<H_DISPLAY && vpos<V_DISPLAY (combinational from registers)
- h_total  output  12  last measured line period, clocks
- v_total  output  12  last measured frame period, lines
- locked  output  1  h_locked && v_locked
- frame_start  output  1  one-cycle pulse while locked with hpos==0 && vpos==0

Behaviour:
- Reset (reset low, asynchronous): all registers 0. hpos=vpos=0, h_total=v_total=0, locked=0, frame_start=0, sync history=0, seen flags=0.
- Edge detect: hsync_d/vsync_d hold the previous-cycle input. h_edge = hsync & ~hsync_d; v_edge = vsync & ~vsync_d. No synchronizer; inputs are same-domain.
- hpos, in priority order:
  - h_edge: load H_SYNC_START+2.
  - hpos==H_MAX: load 0.
  - Otherwise: increment.
  - The +2 makes recovered hpos equal the generator's hpos cycle-for-cycle in loopback.
- vpos, in priority order:
  - v_edge: load V_SYNC_START.
  - hpos==H_MAX and vpos==V_MAX: load 0.
  - hpos==H_MAX only: increment.
  - Otherwise: hold.
  - v_edge takes priority over a wrap in the same cycle.
- Line measure:
  - hmeas increments each cycle, saturating at 4095.
  - On h_edge: if h_seen, h_total<=hmeas. Then hmeas<=1, h_seen<=1.
  - The first edge after reset or timeout produces no measurement.
- Frame measure:
  - vmeas counts h_edges, saturating.
  - On v_edge: if v_seen, v_total<=vmeas. Then vmeas<=(h_edge?1:0) and v_seen<=1.
  - A coincident h_edge is counted in the new frame.
- Horizontal lock:
  - On each measurement, hmatch<=(period==H_TOTAL) ? min(hmatch+1, LOCK_COUNT) : 0.
  - h_locked = (hmatch==LOCK_COUNT).
- Vertical lock: same rule using V_TOTAL, vmatch, v_locked.
- A mismatched period clears the corresponding lock in the cycle after the edge.
- Horizontal timeout: hmeas reaches H_TIMEOUT without h_edge. Clear h_seen, hmatch, h_total, and also v_seen, vmatch, v_total, so locked drops.
- Vertical timeout: vmeas reaches V_TIMEOUT without v_edge. Clear v_seen, vmatch, v_total.
- hpos/vpos keep free-running at nominal timing while unlocked; display_on is forced 0.
- Lock latency from clean input: h_locked after LOCK_COUNT+1 hsync edges; v_locked after LOCK_COUNT+1 vsync edges.
- Reset asserted mid-frame returns everything to reset values immediately. Recovery restarts from the first edges after release.

Test Plan:
- Loopback from crt_controller, same clk, 8 frames -> after 5th vsync edge, locked=1, h_total=800, v_total=525. Thereafter hpos/vpos equal generator outputs every cycle; frame_start pulses once per 420000 clocks.
- Single hsync pulse widened/shifted so one line is 801 clocks -> next cycle h_total=801 and locked=0; relock after 4 further good lines (v_locked unaffected).
- hsync held low for 1600 clocks -> h_total=0, v_total=0, locked=0. On restart, first edge gives no measurement; second edge gives h_total=800.
- v_edge in same cycle as hpos==H_MAX and h_edge -> vpos=490 next cycle; vmeas=1; hpos=658.
- LOCK_COUNT=1 with short stimulus (lines of 800, frames of 525 lines) -> locked after 2nd vsync edge. A 524-line frame clears v_locked; the following 525-line frame restores it.
- reset pulled low at hpos=300, vpos=200 while locked -> all outputs 0 asynchronously. After release, locked stays 0 until 5 good frames.

Source files
------------

// File: rtl/sync_timing_recovery.sv
// Recovers raster position, line/frame periods and lock from active-high
// hsync/vsync that share the pixel clock domain.
module sync_timing_recovery #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_BOTTOM   = 10,
  parameter int V_SYNC     = 2,
  parameter int V_TOP      = 33,
  parameter int LOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        display_on,
  output logic [11:0] h_total,
  output logic [11:0] v_total,
  output logic        locked,
  output logic        frame_start
);

  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int H_MAX        = H_TOTAL - 1;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int V_MAX        = V_TOTAL - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
  localparam int H_TIMEOUT    = 2 * H_TOTAL;
  localparam int V_TIMEOUT    = 2 * V_TOTAL;

  localparam logic [9:0]  C_H_MAX     = 10'(H_MAX);
  localparam logic [9:0]  C_V_MAX     = 10'(V_MAX);
  localparam logic [9:0]  C_H_LOAD    = 10'(H_SYNC_START + 2);
  localparam logic [9:0]  C_V_LOAD    = 10'(V_SYNC_START);
  localparam logic [9:0]  C_H_DISP    = 10'(H_DISPLAY);
  localparam logic [9:0]  C_V_DISP    = 10'(V_DISPLAY);
  localparam logic [11:0] C_H_TOTAL   = 12'(H_TOTAL);
  localparam logic [11:0] C_V_TOTAL   = 12'(V_TOTAL);
  localparam logic [11:0] C_H_TIMEOUT = 12'(H_TIMEOUT);
  localparam logic [11:0] C_V_TIMEOUT = 12'(V_TIMEOUT);
  localparam logic [3:0]  C_LOCK      = 4'(LOCK_COUNT);

  logic        r_hsync_d, r_vsync_d;
  logic [9:0]  r_hpos, r_vpos;
  logic [11:0] r_hmeas, r_vmeas;
  logic [11:0] r_h_total, r_v_total;
  logic        r_h_seen, r_v_seen;
  logic [3:0]  r_hmatch, r_vmatch;

  logic        w_h_edge, w_v_edge, w_h_wrap;
  logic        w_h_timeout, w_v_timeout;
  logic        w_h_locked, w_v_locked;
  logic [3:0]  w_hmatch_next, w_vmatch_next;

  assign w_h_edge    = hsync & ~r_hsync_d;
  assign w_v_edge    = vsync & ~r_vsync_d;
  assign w_h_wrap    = (r_hpos == C_H_MAX);
  assign w_h_timeout = !w_h_edge && (r_hmeas == C_H_TIMEOUT);
  assign w_v_timeout = !w_v_edge && (r_vmeas == C_V_TIMEOUT);

  // A period off nominal restarts the run; a good one climbs to LOCK_COUNT and stays.
  assign w_hmatch_next = (r_hmeas != C_H_TOTAL) ? 4'd0 :
                         (r_hmatch >= C_LOCK)   ? C_LOCK : r_hmatch + 4'd1;
  assign w_vmatch_next = (r_vmeas != C_V_TOTAL) ? 4'd0 :
                         (r_vmatch >= C_LOCK)   ? C_LOCK : r_vmatch + 4'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hsync_d <= 1'b0;
      r_vsync_d <= 1'b0;
      r_hpos    <= '0;
      r_vpos    <= '0;
    end else begin
      r_hsync_d <= hsync;
      r_vsync_d <= vsync;

      if (w_h_edge)      r_hpos <= C_H_LOAD;
      else if (w_h_wrap) r_hpos <= '0;
      else               r_hpos <= r_hpos + 10'd1;

      if (w_v_edge)                           r_vpos <= C_V_LOAD;
      else if (w_h_wrap && r_vpos == C_V_MAX) r_vpos <= '0;
      else if (w_h_wrap)                      r_vpos <= r_vpos + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hmeas   <= '0;
      r_vmeas   <= '0;
      r_h_total <= '0;
      r_v_total <= '0;
      r_h_seen  <= 1'b0;
      r_v_seen  <= 1'b0;
      r_hmatch  <= '0;
      r_vmatch  <= '0;
    end else begin
      if (w_h_edge) begin
        if (r_h_seen) begin
          r_h_total <= r_hmeas;
          r_hmatch  <= w_hmatch_next;
        end
        r_hmeas  <= 12'd1;
        r_h_seen <= 1'b1;
      end else if (r_hmeas != '1) begin
        r_hmeas <= r_hmeas + 12'd1;
      end

      // A line edge coincident with the frame edge belongs to the new frame.
      if (w_v_edge) begin
        if (r_v_seen) begin
          r_v_total <= r_vmeas;
          r_vmatch  <= w_vmatch_next;
        end
        r_vmeas  <= {11'd0, w_h_edge};
        r_v_seen <= 1'b1;
      end else if (w_h_edge && r_vmeas != '1) begin
        r_vmeas <= r_vmeas + 12'd1;
      end

      // Timeouts come last so they override any update made above.
      if (w_h_timeout) begin
        r_h_seen  <= 1'b0;
        r_hmatch  <= '0;
        r_h_total <= '0;
      end
      if (w_h_timeout || w_v_timeout) begin
        r_v_seen  <= 1'b0;
        r_vmatch  <= '0;
        r_v_total <= '0;
      end
    end
  end

  assign w_h_locked  = (r_hmatch == C_LOCK);
  assign w_v_locked  = (r_vmatch == C_LOCK);

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign h_total     = r_h_total;
  assign v_total     = r_v_total;
  assign locked      = w_h_locked && w_v_locked;
  assign display_on  = locked && (r_hpos < C_H_DISP) && (r_vpos < C_V_DISP);
  assign frame_start = locked && (r_hpos == '0) && (r_vpos == '0);

endmodule

// File: tb/tb_sync_timing_recovery.sv
// Directed bench for sync_timing_recovery on a scaled-down raster (24x13),
// driven by an in-bench sync generator with registered sync outputs.
module tb_sync_timing_recovery;

  localparam int H_DISPLAY = 12, H_FRONT = 3, H_SYNC = 4, H_BACK = 5;
  localparam int V_DISPLAY = 6, V_BOTTOM = 2, V_SYNC = 2, V_TOP = 3;
  localparam int H_TOTAL = 24, H_MAX = 23, H_SS = 15;
  localparam int V_TOTAL = 13, V_MAX = 12, V_SS = 8;
  localparam int H_TIMEOUT = 2 * H_TOTAL;
  localparam int FRAME = H_TOTAL * V_TOTAL;

  logic clk = 1'b0, reset = 1'b1, hsync = 1'b0, vsync = 1'b0;

  logic [9:0]  o0_hpos, o0_vpos, o1_hpos, o1_vpos;
  logic [11:0] o0_h_total, o0_v_total, o1_h_total, o1_v_total;
  logic        o0_display_on, o0_locked, o0_frame_start;
  logic        o1_display_on, o1_locked, o1_frame_start;

  int checks = 0, errors = 0;
  int gh = 0, gv = 0, nh = 0, nv = 0, cyc = 0;
  int pos_err = 0, disp_err = 0, fs_err = 0, fs_cnt = 0;
  logic hs_q = 1'b0, vs_q = 1'b0;
  logic h_mask = 1'b0, manual = 1'b0, m_hs = 1'b0, m_vs = 1'b0, stall = 1'b0, skip = 1'b0;
  logic [1:0] seq [6] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01};

  sync_timing_recovery #(
    .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISPLAY(V_DISPLAY), .V_BOTTOM(V_BOTTOM), .V_SYNC(V_SYNC), .V_TOP(V_TOP),
    .LOCK_COUNT(4)
  ) u_dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .hpos(o0_hpos), .vpos(o0_vpos), .display_on(o0_display_on),
    .h_total(o0_h_total), .v_total(o0_v_total), .locked(o0_locked),
    .frame_start(o0_frame_start)
  );

  sync_timing_recovery #(
    .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISPLAY(V_DISPLAY), .V_BOTTOM(V_BOTTOM), .V_SYNC(V_SYNC), .V_TOP(V_TOP),
    .LOCK_COUNT(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .hpos(o1_hpos), .vpos(o1_vpos), .display_on(o1_display_on),
    .h_total(o1_h_total), .v_total(o1_v_total), .locked(o1_locked),
    .frame_start(o1_frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel clock: drive at negedge, advance the generator at posedge,
  // return 1 time unit after the edge with DUT state for the new cycle.
  task automatic tick();
    logic nhs, nvs;
    @(negedge clk);
    nhs = manual ? m_hs : (hs_q & ~h_mask);
    nvs = manual ? m_vs : vs_q;
    if (nhs && !hsync) nh++;
    if (nvs && !vsync) nv++;
    hsync = nhs;
    vsync = nvs;
    @(posedge clk);
    hs_q = (gh >= H_SS) && (gh < H_SS + H_SYNC);
    vs_q = (gv >= V_SS) && (gv < V_SS + V_SYNC);
    if (stall) stall = 1'b0;
    else if (gh == H_MAX) begin
      gh = 0;
      if (skip && gv == 2) begin gv = 4; skip = 1'b0; end
      else gv = (gv == V_MAX) ? 0 : gv + 1;
    end else gh++;
    #1;
  endtask

  task automatic wait_v(input int n);
    int target, c;
    target = nv + n;
    c = 0;
    while (nv < target && c < (n + 1) * 2 * FRAME) begin tick(); c++; end
    check("wait_vsync_edge", (nv >= target), 1);
  endtask

  task automatic wait_h(input int n);
    int target, c;
    target = nh + n;
    c = 0;
    while (nh < target && c < (n + 1) * 4 * H_TOTAL) begin tick(); c++; end
    check("wait_hsync_edge", (nh >= target), 1);
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b0;
    repeat (3) tick();
    check("rst_hpos", o0_hpos, 0);
    check("rst_vpos", o0_vpos, 0);
    check("rst_h_total", o0_h_total, 0);
    check("rst_v_total", o0_v_total, 0);
    check("rst_locked", o0_locked, 0);
    check("rst_frame_start", o0_frame_start, 0);
    check("rst_display_on", o0_display_on, 0);
    check("rst1_pos", {o1_hpos, o1_vpos}, 0);
    check("rst1_totals", {o1_h_total, o1_v_total}, 0);
    check("rst1_flags", {o1_display_on, o1_locked, o1_frame_start}, 0);
    reset = 1'b1;
    nh = 0;
    nv = 0;

    // Loopback lock-up
    wait_v(1);
    check("lc1_locked_after_1st_v", o1_locked, 0);
    wait_v(1);
    check("lc1_locked_after_2nd_v", o1_locked, 1);
    check("lc4_locked_after_2nd_v", o0_locked, 0);
    wait_v(2);
    check("lc4_locked_after_4th_v", o0_locked, 0);
    wait_v(1);
    check("lc4_locked_after_5th_v", o0_locked, 1);
    check("loop_h_total", o0_h_total, H_TOTAL);
    check("loop_v_total", o0_v_total, V_TOTAL);

    // Cycle-for-cycle tracking over two frames
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (o0_hpos !== 10'(gh) || o0_vpos !== 10'(gv)) pos_err++;
      if (o0_display_on !== ((gh < H_DISPLAY) && (gv < V_DISPLAY))) disp_err++;
      if (o0_frame_start !== ((gh == 0) && (gv == 0))) fs_err++;
      if (o0_frame_start === 1'b1) fs_cnt++;
    end
    check("track_pos_mismatches", pos_err, 0);
    check("track_display_mismatches", disp_err, 0);
    check("track_frame_start_mismatches", fs_err, 0);
    check("track_frame_start_count", fs_cnt, 2);

    // One short frame (V_TOTAL-1 lines), then good frames
    wait_v(1);
    skip = 1'b1;
    wait_v(1);
    check("short_v_total", o0_v_total, V_TOTAL - 1);
    check("short_lc1_locked", o1_locked, 0);
    check("short_lc4_locked", o0_locked, 0);
    wait_v(1);
    check("good_v_total", o0_v_total, V_TOTAL);
    check("good_lc1_relocked", o1_locked, 1);
    check("good_lc4_still_unlocked", o0_locked, 0);
    wait_v(2);
    check("lc4_unlocked_3_good", o0_locked, 0);
    wait_v(1);
    check("lc4_relocked_4_good", o0_locked, 1);

    // One stretched line (H_TOTAL+1 clocks)
    cyc = 0;
    while (gh != 2 && cyc < 2 * H_TOTAL) begin tick(); cyc++; end
    stall = 1'b1;
    wait_h(1);
    check("long_h_total", o0_h_total, H_TOTAL + 1);
    check("long_lc4_locked", o0_locked, 0);
    check("long_lc1_locked", o1_locked, 0);
    wait_h(1);
    check("long_next_h_total", o0_h_total, H_TOTAL);
    check("long_lc1_relocked", o1_locked, 1);
    wait_h(2);
    check("long_lc4_unlocked_3_good", o0_locked, 0);
    wait_h(1);
    check("long_lc4_relocked_4_good", o0_locked, 1);

    // hsync lost: timeout after H_TIMEOUT clocks without an edge
    wait_h(1);
    h_mask = 1'b1;
    repeat (H_TIMEOUT - 1) tick();
    check("to_h_total_before", o0_h_total, H_TOTAL);
    tick();
    check("to_h_total", o0_h_total, 0);
    check("to_v_total", o0_v_total, 0);
    check("to_locked", o0_locked, 0);
    check("to_lc1_locked", o1_locked, 0);
    cyc = 0;
    while (gh != 0 && cyc < 2 * H_TOTAL) begin tick(); cyc++; end
    h_mask = 1'b0;
    wait_h(1);
    check("restart_first_edge_no_meas", o0_h_total, 0);
    wait_h(1);
    check("restart_second_edge", o0_h_total, H_TOTAL);

    // v_edge + h_edge coincident with hpos==H_MAX
    wait_v(1);
    manual = 1'b1;
    m_hs = 1'b0;
    m_vs = 1'b0;
    tick();
    cyc = 0;
    while (o0_hpos != 10'(H_MAX) && cyc < 2 * H_TOTAL) begin tick(); cyc++; end
    check("coinc_reach_hmax", o0_hpos, H_MAX);
    m_hs = 1'b1;
    m_vs = 1'b1;
    tick();
    check("coinc_vpos", o0_vpos, V_SS);
    check("coinc_hpos", o0_hpos, H_SS + 2);
    check("coinc_v_total_empty_frame", o0_v_total, 0);
    for (int i = 0; i < 6; i++) begin
      m_hs = seq[i][1];
      m_vs = seq[i][0];
      tick();
    end
    check("coinc_vmeas_counts_edge", o0_v_total, 3);
    check("coinc_vpos_reload", o0_vpos, V_SS);
    manual = 1'b0;

    // Asynchronous reset mid-frame while locked
    cyc = 0;
    while (!(o0_locked === 1'b1 && o0_hpos == 10'd7 && o0_vpos == 10'd3) && cyc < 14 * FRAME) begin
      tick();
      cyc++;
    end
    check("pre_reset_locked", o0_locked, 1);
    check("pre_reset_display_on", o0_display_on, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_pos", {o0_hpos, o0_vpos}, 0);
    check("async_rst_totals", {o0_h_total, o0_v_total}, 0);
    check("async_rst_flags", {o0_display_on, o0_locked, o0_frame_start}, 0);
    repeat (2) tick();
    reset = 1'b1;
    nh = 0;
    nv = 0;
    wait_v(4);
    check("post_rst_unlocked_4v", o0_locked, 0);
    wait_v(1);
    check("post_rst_locked_5v", o0_locked, 1);
    check("post_rst_v_total", o0_v_total, V_TOTAL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
